// File: rtl/sys_bus_pkg.sv
// Shared types and constants for the sys_bus_ic system-bus interconnect.
package sys_bus_pkg;

    localparam int DATA_W = 32;
    localparam int BE_W   = 4;

    localparam logic [DATA_W-1:0] ERR_DATA_DEFAULT = 32'hBADB_0BAD;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } bus_state_e;

endpackage

// File: rtl/sys_bus_timeout.sv
// Slave-response watchdog: counts waiting cycles, flags expiry at TIMEOUT-1.
module sys_bus_timeout #(
    parameter int TIMEOUT = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam int CNT_W = $clog2(TIMEOUT) + 1;

    logic [CNT_W-1:0] cnt_r;

    // Wait-cycle counter; clear wins over enable.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r <= '0;
        end else if (clr) begin
            cnt_r <= '0;
        end else if (en) begin
            cnt_r <= cnt_r + CNT_W'(1);
        end else begin
            cnt_r <= cnt_r;
        end
    end

    assign expired = (cnt_r == CNT_W'(TIMEOUT - 1));

endmodule

// File: rtl/sys_bus_ic.sv
// System-bus interconnect: routes one LSU transaction at a time to a slave chosen by addr[31:SEL_LSB].
// Optional first-error address capture is enabled by defining SYS_BUS_ERR_CAPTURE_EN.
module sys_bus_ic
    import sys_bus_pkg::*;
#(
    parameter int                    N_SLAVES   = 8,
    parameter int                    SEL_LSB    = 24,
    parameter logic [N_SLAVES-1:0]   SLAVE_MASK = N_SLAVES'(8'hFF),
    parameter int                    TIMEOUT    = 16,
    parameter logic [DATA_W-1:0]     ERR_DATA   = ERR_DATA_DEFAULT
) (
    input  logic                       clk_i,
    input  logic                       resetn_i,
    input  logic                       m_req_i,
    input  logic                       m_we_i,
    input  logic [BE_W-1:0]            m_be_i,
    input  logic [DATA_W-1:0]          m_addr_i,
    input  logic [DATA_W-1:0]          m_wd_i,
    output logic [DATA_W-1:0]          m_rd_o,
    output logic                       m_ready_o,
    output logic                       m_err_o,
    output logic [N_SLAVES-1:0]        s_req_o,
    output logic                       s_we_o,
    output logic [BE_W-1:0]            s_be_o,
    output logic [DATA_W-1:0]          s_addr_o,
    output logic [DATA_W-1:0]          s_wd_o,
    input  logic [DATA_W*N_SLAVES-1:0] s_rd_i,
    input  logic [N_SLAVES-1:0]        s_ready_i
`ifdef SYS_BUS_ERR_CAPTURE_EN
    ,
    output logic                       err_valid_o,
    output logic [DATA_W-1:0]          err_addr_o,
    input  logic                       err_clr_i
`endif
);

    localparam int                IDX_W    = DATA_W - SEL_LSB;
    localparam logic [DATA_W-1:0] LOW_MASK = (32'd1 << SEL_LSB) - 32'd1;

    bus_state_e          state_r, state_nxt_s;
    logic [IDX_W-1:0]    idx_r, idx_nxt_s, req_idx_s;
    logic                req_mapped_s, sel_ready_s, expired_s;
    logic [DATA_W-1:0]   sel_rd_s, rd_r, rd_nxt_s, addr_r, wd_r;
    logic                err_r, err_nxt_s, ready_r, we_r;
    logic [BE_W-1:0]     be_r;
    logic [N_SLAVES-1:0] s_req_r, s_req_nxt_s;

    assign req_idx_s = m_addr_i[DATA_W-1:SEL_LSB];

    // AND-OR decode: out-of-range indices match no slave and so read as unmapped.
    always_comb begin
        req_mapped_s = 1'b0;
        sel_ready_s  = 1'b0;
        sel_rd_s     = '0;
        for (int i = 0; i < N_SLAVES; i++) begin
            req_mapped_s = req_mapped_s | ((32'(req_idx_s) == 32'(i)) & SLAVE_MASK[i]);
            sel_ready_s  = sel_ready_s  | ((32'(idx_r) == 32'(i)) & s_ready_i[i]);
            sel_rd_s     = sel_rd_s | ({DATA_W{32'(idx_r) == 32'(i)}} & s_rd_i[DATA_W*i +: DATA_W]);
        end
    end

    // Next-state and response-data selection; slave ready takes priority over expiry.
    always_comb begin
        state_nxt_s = state_r;
        idx_nxt_s   = idx_r;
        rd_nxt_s    = rd_r;
        err_nxt_s   = err_r;
        case (state_r)
            IDLE: begin
                if (m_req_i) begin
                    idx_nxt_s = req_idx_s;
                    if (req_mapped_s) begin
                        state_nxt_s = BUSY;
                        err_nxt_s   = 1'b0;
                    end else begin
                        state_nxt_s = RESP;
                        err_nxt_s   = 1'b1;
                        rd_nxt_s    = ERR_DATA;
                    end
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            BUSY: begin
                if (sel_ready_s) begin
                    state_nxt_s = RESP;
                    rd_nxt_s    = sel_rd_s;
                    err_nxt_s   = 1'b0;
                end else if (expired_s) begin
                    state_nxt_s = RESP;
                    rd_nxt_s    = ERR_DATA;
                    err_nxt_s   = 1'b1;
                end else begin
                    state_nxt_s = BUSY;
                end
            end
            RESP:    state_nxt_s = IDLE;
            default: state_nxt_s = IDLE;
        endcase
    end

    // One-hot slave request for the coming cycle, so s_req_o comes straight from a flop.
    always_comb begin
        s_req_nxt_s = '0;
        for (int i = 0; i < N_SLAVES; i++) begin
            s_req_nxt_s[i] = (state_nxt_s == BUSY) && (32'(idx_nxt_s) == 32'(i));
        end
    end

    // State, response and request registers.
    always_ff @(posedge clk_i or negedge resetn_i) begin
        if (!resetn_i) begin
            state_r <= IDLE;
            idx_r   <= '0;
            rd_r    <= '0;
            err_r   <= 1'b0;
            ready_r <= 1'b0;
            s_req_r <= '0;
        end else begin
            state_r <= state_nxt_s;
            idx_r   <= idx_nxt_s;
            rd_r    <= rd_nxt_s;
            err_r   <= err_nxt_s;
            ready_r <= (state_nxt_s == RESP);
            s_req_r <= s_req_nxt_s;
        end
    end

    // Transaction attributes are latched once on acceptance and stay stable through BUSY.
    always_ff @(posedge clk_i or negedge resetn_i) begin
        if (!resetn_i) begin
            addr_r <= '0;
            wd_r   <= '0;
            be_r   <= '0;
            we_r   <= 1'b0;
        end else if ((state_r == IDLE) && m_req_i) begin
            addr_r <= m_addr_i;
            wd_r   <= m_wd_i;
            be_r   <= m_be_i;
            we_r   <= m_we_i;
        end else begin
            addr_r <= addr_r;
            wd_r   <= wd_r;
            be_r   <= be_r;
            we_r   <= we_r;
        end
    end

    sys_bus_timeout #(
        .TIMEOUT (TIMEOUT)
    ) u_timeout (
        .clk     (clk_i),
        .rst_n   (resetn_i),
        .clr     (state_r == IDLE),
        .en      ((state_r == BUSY) && !sel_ready_s),
        .expired (expired_s)
    );

    assign m_rd_o    = rd_r;
    assign m_ready_o = ready_r;
    assign m_err_o   = err_r;
    assign s_req_o   = s_req_r;
    assign s_we_o    = we_r;
    assign s_be_o    = be_r;
    assign s_addr_o  = addr_r & LOW_MASK;
    assign s_wd_o    = wd_r;

`ifdef SYS_BUS_ERR_CAPTURE_EN
    logic              err_valid_r, err_evt_s;
    logic [DATA_W-1:0] err_addr_r, err_evt_addr_s;

    // Unmapped errors are known while still in IDLE, before addr_r has been loaded.
    assign err_evt_s      = (state_nxt_s == RESP) && err_nxt_s;
    assign err_evt_addr_s = (state_r == IDLE) ? m_addr_i : addr_r;

    // Sticky first-error capture; a clear coinciding with a new error re-arms on that error.
    always_ff @(posedge clk_i or negedge resetn_i) begin
        if (!resetn_i) begin
            err_valid_r <= 1'b0;
            err_addr_r  <= '0;
        end else if (err_evt_s && (!err_valid_r || err_clr_i)) begin
            err_valid_r <= 1'b1;
            err_addr_r  <= err_evt_addr_s;
        end else if (err_clr_i) begin
            err_valid_r <= 1'b0;
            err_addr_r  <= '0;
        end else begin
            err_valid_r <= err_valid_r;
            err_addr_r  <= err_addr_r;
        end
    end

    assign err_valid_o = err_valid_r;
    assign err_addr_o  = err_addr_r;
`endif

endmodule

// File: tb/tb_sys_bus_ic.sv
// Self-checking bench for sys_bus_ic: directed cases plus random transactions against a latency/response model.
module tb_sys_bus_ic;

    localparam int          NS      = 8;
    localparam int          TO      = 16;
    localparam logic [31:0] ERRD    = 32'hBADB_0BAD;
    localparam logic [7:0]  MASK_P  = 8'hDF;

    logic         clk = 1'b0;
    logic         resetn_i;
    logic         m_req_i, m_we_i;
    logic [3:0]   m_be_i;
    logic [31:0]  m_addr_i, m_wd_i, m_rd_o;
    logic         m_ready_o, m_err_o;
    logic [7:0]   s_req_o;
    logic         s_we_o;
    logic [3:0]   s_be_o;
    logic [31:0]  s_addr_o, s_wd_o;
    logic [255:0] s_rd_i;
    logic [7:0]   s_ready_i;
`ifdef SYS_BUS_ERR_CAPTURE_EN
    logic         err_valid_o, err_clr_i;
    logic [31:0]  err_addr_o;
`endif

    int n_assert = 0;
    int n_fail   = 0;
    logic [7:0] mask_tb = MASK_P;

    sys_bus_ic #(
        .N_SLAVES (NS), .SEL_LSB (24), .SLAVE_MASK (MASK_P), .TIMEOUT (TO), .ERR_DATA (ERRD)
    ) dut (
        .clk_i (clk), .resetn_i (resetn_i),
        .m_req_i (m_req_i), .m_we_i (m_we_i), .m_be_i (m_be_i), .m_addr_i (m_addr_i), .m_wd_i (m_wd_i),
        .m_rd_o (m_rd_o), .m_ready_o (m_ready_o), .m_err_o (m_err_o),
        .s_req_o (s_req_o), .s_we_o (s_we_o), .s_be_o (s_be_o), .s_addr_o (s_addr_o), .s_wd_o (s_wd_o),
        .s_rd_i (s_rd_i), .s_ready_i (s_ready_i)
`ifdef SYS_BUS_ERR_CAPTURE_EN
        , .err_valid_o (err_valid_o), .err_addr_o (err_addr_o), .err_clr_i (err_clr_i)
`endif
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic rand_rd();
        for (int i = 0; i < NS; i++) s_rd_i[32*i +: 32] = $urandom;
    endtask

    // Issue one transaction (entered and left in an IDLE cycle, #1 after a clock edge).
    // delay = number of BUSY cycles before the selected slave raises ready.
    task automatic run_txn(input logic [31:0] addr, input logic we, input logic [3:0] be,
                           input logic [31:0] wd, input int delay,
                           input bit use_fix, input logic [31:0] fix_rd);
        int          idx     = int'(addr[31:24]);
        bit          mapped  = (idx < NS) && mask_tb[idx];
        logic [7:0]  sel     = (idx < NS) ? (8'd1 << idx) : 8'd0;
        logic [31:0] rec_rd  = 32'd0;
        bit          done    = 1'b0;
        int          exp_lat;
        logic [31:0] exp_rd;
        logic        exp_err;
        if (!mapped) begin
            exp_lat = 1; exp_err = 1'b1; exp_rd = ERRD;
        end else if (delay <= TO - 1) begin
            exp_lat = delay + 2; exp_err = 1'b0;
        end else begin
            exp_lat = TO + 1; exp_err = 1'b1; exp_rd = ERRD;
        end
        m_req_i = 1'b1; m_we_i = we; m_be_i = be; m_addr_i = addr; m_wd_i = wd;
        s_ready_i = 8'($urandom) & ~sel;
        rand_rd();
        for (int cyc = 1; cyc <= 40 && !done; cyc++) begin
            @(posedge clk); #1;
            if (m_ready_o === 1'b1) begin
                if (mapped && delay <= TO - 1) exp_rd = rec_rd;
                check("latency", 32'(cyc), 32'(exp_lat));
                check("m_err", {31'd0, m_err_o}, {31'd0, exp_err});
                check("m_rd", m_rd_o, exp_rd);
                check("s_req_in_resp", {24'd0, s_req_o}, 32'd0);
                done = 1'b1;
                m_req_i = 1'b0;
                s_ready_i = 8'd0;
            end else begin
                check("s_req", {24'd0, s_req_o}, mapped ? {24'd0, sel} : 32'd0);
                if (mapped) begin
                    check("s_addr", s_addr_o, addr % 32'h0100_0000);
                    check("s_wd", s_wd_o, wd);
                    check("s_be_we", {27'd0, s_we_o, s_be_o}, {27'd0, we, be});
                end
                s_ready_i = 8'($urandom) & ~sel;
                rand_rd();
                if (mapped && (cyc - 1 == delay)) begin
                    s_ready_i = s_ready_i | sel;
                    if (use_fix) s_rd_i[32*idx +: 32] = fix_rd;
                    rec_rd = s_rd_i[32*idx +: 32];
                end
            end
        end
        if (!done) begin
            n_assert++; n_fail++;
            $error("FAIL txn_no_ready: observed no m_ready_o within 40 cycles expected latency %0d", exp_lat);
            m_req_i = 1'b0;
            s_ready_i = 8'd0;
        end
        @(posedge clk); #1;
        check("ready_pulse_once", {31'd0, m_ready_o}, 32'd0);
    endtask

    initial begin
        int          ridx, rdly;
        logic [31:0] raddr;
        resetn_i = 1'b0; m_req_i = 1'b0; m_we_i = 1'b0; m_be_i = 4'd0;
        m_addr_i = 32'd0; m_wd_i = 32'd0; s_rd_i = '0; s_ready_i = 8'd0;
`ifdef SYS_BUS_ERR_CAPTURE_EN
        err_clr_i = 1'b0;
`endif
        repeat (3) @(posedge clk);
        #1;
        check("rst_s_req", {24'd0, s_req_o}, 32'd0);
        check("rst_ready_err", {30'd0, m_ready_o, m_err_o}, 32'd0);
        check("rst_m_rd", m_rd_o, 32'd0);
        resetn_i = 1'b1;
        @(posedge clk); #1;

`ifdef SYS_BUS_ERR_CAPTURE_EN
        check("ec_rst_valid", {31'd0, err_valid_o}, 32'd0);
        run_txn(32'h0A00_0004, 1'b0, 4'hF, 32'd0, 0, 1'b0, 32'd0);
        run_txn(32'h0B00_0008, 1'b0, 4'hF, 32'd0, 0, 1'b0, 32'd0);
        check("ec_valid", {31'd0, err_valid_o}, 32'd1);
        check("ec_first_addr", err_addr_o, 32'h0A00_0004);
        err_clr_i = 1'b1;
        @(posedge clk); #1;
        err_clr_i = 1'b0;
        check("ec_cleared", {31'd0, err_valid_o}, 32'd0);
        run_txn(32'h0C00_000C, 1'b0, 4'hF, 32'd0, 0, 1'b0, 32'd0);
        check("ec_recapture", err_addr_o, 32'h0C00_000C);
        check("ec_valid2", {31'd0, err_valid_o}, 32'd1);
`endif

        // Directed cases
        run_txn(32'h0300_0010, 1'b0, 4'hF, 32'd0, 0, 1'b1, 32'h1234_5678);
        run_txn(32'h0700_0020, 1'b1, 4'b0011, 32'hCAFE_F00D, 3, 1'b0, 32'd0);
        run_txn(32'h0900_0000, 1'b0, 4'hF, 32'd0, 0, 1'b0, 32'd0);
        run_txn(32'h0500_0000, 1'b0, 4'hF, 32'd0, 0, 1'b0, 32'd0);
        run_txn(32'h0200_0000, 1'b0, 4'hF, 32'd0, 99, 1'b0, 32'd0);
        run_txn(32'h0200_0004, 1'b0, 4'hF, 32'd0, TO - 1, 1'b0, 32'd0);

        // Asynchronous reset during BUSY
        m_req_i = 1'b1; m_we_i = 1'b0; m_addr_i = 32'h0100_0040; s_ready_i = 8'd0;
        @(posedge clk); #1;
        check("pre_rst_s_req", {24'd0, s_req_o}, 32'h0000_0002);
        #2;
        resetn_i = 1'b0;
        m_req_i = 1'b0;
        #1;
        check("async_rst_s_req", {24'd0, s_req_o}, 32'd0);
        check("async_rst_ready", {31'd0, m_ready_o}, 32'd0);
        check("async_rst_m_rd", m_rd_o, 32'd0);
        @(posedge clk); @(posedge clk); #1;
        resetn_i = 1'b1;
        @(posedge clk); #1;
        run_txn(32'h0400_0100, 1'b0, 4'hF, 32'd0, 1, 1'b1, 32'h0BAD_CAFE);

        // Random transactions
        for (int t = 0; t < 40; t++) begin
            ridx  = $urandom_range(0, 11);
            raddr = {8'(ridx), 24'($urandom)};
            rdly  = ($urandom_range(0, 3) == 0) ? $urandom_range(TO - 2, TO + 2) : $urandom_range(0, 5);
            run_txn(raddr, 1'($urandom), 4'($urandom), $urandom, rdly, 1'b0, 32'd0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
